// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers (one step per cycle).
// Define MDU_DIV_EN to include the restoring divider; otherwise DIV/DIVU behave as NOP.
module mul_div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic [2:0]            Op,
    input  logic                  Start,
    input  logic                  HiLoSel,
    output logic [DATA_WIDTH-1:0] HiLoOut,
    output logic                  Busy,
    output logic                  Done,
    output logic                  DivZero
);
    localparam int W = DATA_WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
`endif
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef MDU_DIV_EN
        S_DIV  = 2'd3,
`endif
        S_FIX  = 2'd2
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] cnt_dec;
    logic [W-1:0]         hi_reg;
    logic [W-1:0]         lo_reg;
    logic [W-1:0]         opnd_reg;
    logic [2*W-1:0]       acc_reg;
    logic                 neg_reg;
    logic                 done_reg;

    logic                 start_mul;
    logic                 signed_op;
    logic [W-1:0]         a_mag;
    logic [W-1:0]         b_mag;
    logic [W:0]           mul_sum;
    logic [2*W-1:0]       mul_step;
    logic [2*W-1:0]       acc_step;
    logic [2*W-1:0]       prod_signed;
    logic [W-1:0]         fix_hi;
    logic [W-1:0]         fix_lo;

`ifdef MDU_DIV_EN
    logic                 start_div;
    logic                 is_div_reg;
    logic                 rem_neg_reg;
    logic                 dz_reg;
    logic                 divzero_reg;
    logic [W-1:0]         orig_a_reg;
    logic [W:0]           rem_shift;
    logic [W:0]           div_diff;
    logic [2*W-1:0]       div_step;
    logic [W-1:0]         quot;
    logic [W-1:0]         rem;
`endif

    // Operand decode: magnitudes are taken only for the signed opcodes.
    always_comb begin
        start_mul = Start && ((Op == OP_MULT) || (Op == OP_MULTU));
`ifdef MDU_DIV_EN
        start_div = Start && ((Op == OP_DIV) || (Op == OP_DIVU));
        signed_op = (Op == OP_MULT) || (Op == OP_DIV);
`else
        signed_op = (Op == OP_MULT);
`endif
        a_mag = (signed_op && SrcA[W-1]) ? -SrcA : SrcA;
        b_mag = (signed_op && SrcB[W-1]) ? -SrcB : SrcB;
    end

    // Iteration datapath. acc_reg holds {partial product, multiplier} for
    // multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        cnt_dec  = cnt_reg - CNT_LAST;
        mul_sum  = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, opnd_reg} : {(W+1){1'b0}});
        mul_step = {mul_sum, acc_reg[W-1:1]};
`ifdef MDU_DIV_EN
        rem_shift = {acc_reg[2*W-1:W], acc_reg[W-1]};
        div_diff  = rem_shift - {1'b0, opnd_reg};
        div_step  = div_diff[W] ? {rem_shift[W-1:0], acc_reg[W-2:0], 1'b0}
                                : {div_diff[W-1:0],  acc_reg[W-2:0], 1'b1};
        acc_step  = is_div_reg ? div_step : mul_step;
`else
        acc_step  = mul_step;
`endif
    end

    // FIX consumes the final iteration directly, then applies the signs.
    always_comb begin
        prod_signed = neg_reg ? -acc_step : acc_step;
        fix_hi      = prod_signed[2*W-1:W];
        fix_lo      = prod_signed[W-1:0];
`ifdef MDU_DIV_EN
        quot = acc_step[W-1:0];
        rem  = acc_step[2*W-1:W];
        if (is_div_reg) begin
            if (dz_reg) begin
                fix_hi = orig_a_reg;
                fix_lo = {W{1'b1}};
            end else begin
                fix_hi = rem_neg_reg ? -rem : rem;
                fix_lo = neg_reg ? -quot : quot;
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_mul) begin
                    state_next = S_MUL;
                end
`ifdef MDU_DIV_EN
                else if (start_div) begin
                    state_next = S_DIV;
                end
`endif
            end
            S_MUL: begin
                if (cnt_dec == CNT_LAST) begin
                    state_next = S_FIX;
                end
            end
`ifdef MDU_DIV_EN
            S_DIV: begin
                if (cnt_dec == CNT_LAST) begin
                    state_next = S_FIX;
                end
            end
`endif
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy    = (state_reg != S_IDLE);
        Done    = done_reg;
        HiLoOut = HiLoSel ? hi_reg : lo_reg;
`ifdef MDU_DIV_EN
        DivZero = divzero_reg;
`else
        DivZero = 1'b0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            hi_reg      <= '0;
            lo_reg      <= '0;
            acc_reg     <= '0;
            opnd_reg    <= '0;
            cnt_reg     <= '0;
            neg_reg     <= 1'b0;
            done_reg    <= 1'b0;
`ifdef MDU_DIV_EN
            is_div_reg  <= 1'b0;
            rem_neg_reg <= 1'b0;
            dz_reg      <= 1'b0;
            divzero_reg <= 1'b0;
            orig_a_reg  <= '0;
`endif
        end else begin
            done_reg    <= 1'b0;
`ifdef MDU_DIV_EN
            divzero_reg <= 1'b0;
`endif
            case (state_reg)
                S_IDLE: begin
                    if (Start) begin
                        case (Op)
                            OP_MULT, OP_MULTU: begin
                                acc_reg  <= {{W{1'b0}}, b_mag};
                                opnd_reg <= a_mag;
                                neg_reg  <= signed_op && (SrcA[W-1] ^ SrcB[W-1]);
                                cnt_reg  <= CNT_LOAD;
`ifdef MDU_DIV_EN
                                is_div_reg <= 1'b0;
                                dz_reg     <= 1'b0;
`endif
                            end
`ifdef MDU_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                acc_reg     <= {{W{1'b0}}, a_mag};
                                opnd_reg    <= b_mag;
                                neg_reg     <= signed_op && (SrcA[W-1] ^ SrcB[W-1]);
                                rem_neg_reg <= signed_op && SrcA[W-1];
                                dz_reg      <= (SrcB == '0);
                                orig_a_reg  <= SrcA;
                                is_div_reg  <= 1'b1;
                                cnt_reg     <= CNT_LOAD;
                            end
`endif
                            OP_MTHI: hi_reg <= SrcA;
                            OP_MTLO: lo_reg <= SrcA;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_dec;
                end
`ifdef MDU_DIV_EN
                S_DIV: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_dec;
                end
`endif
                S_FIX: begin
                    hi_reg   <= fix_hi;
                    lo_reg   <= fix_lo;
                    done_reg <= 1'b1;
                    cnt_reg  <= '0;
`ifdef MDU_DIV_EN
                    divzero_reg <= is_div_reg && dz_reg;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized ops against an arithmetic model.
// Expectations for DIV/DIVU follow MDU_DIV_EN in the same way as the design.
module tb_mul_div_unit;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam logic [2:0] NOP = 3'b000, MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011,
                           DIVU = 3'b100, MTHI = 3'b101, MTLO = 3'b110;

    logic        CLK = 1'b0;
    logic        rst;
    logic [31:0] SrcA, SrcB;
    logic [2:0]  Op;
    logic        Start, HiLoSel;
    logic [31:0] HiLoOut;
    logic        Busy, Done, DivZero;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hi, exp_lo;
    logic [2:0]  prim;

    mul_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .CLK(CLK), .rst(rst), .SrcA(SrcA), .SrcB(SrcB), .Op(Op), .Start(Start),
        .HiLoSel(HiLoSel), .HiLoOut(HiLoOut), .Busy(Busy), .Done(Done), .DivZero(DivZero)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Reference: plain 64-bit arithmetic on the architectural meaning of each opcode.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output bit is_long, output bit dz);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        is_long = 1'b0;
        dz      = 1'b0;
        case (op)
            MULT: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                exp_hi = p[63:32]; exp_lo = p[31:0]; is_long = 1'b1;
            end
            MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                exp_hi = p[63:32]; exp_lo = p[31:0]; is_long = 1'b1;
            end
            DIV, DIVU: begin
                if (DIV_EN) begin
                    is_long = 1'b1;
                    if (b == 32'h0) begin
                        dz = 1'b1; exp_hi = a; exp_lo = 32'hFFFF_FFFF;
                    end else if (op == DIV) begin
                        sa = longint'($signed(a)); sb = longint'($signed(b));
                        sq = sa / sb; sr = sa % sb;
                        p = 64'(sq); exp_lo = p[31:0];
                        p = 64'(sr); exp_hi = p[31:0];
                    end else begin
                        exp_lo = a / b; exp_hi = a % b;
                    end
                end
            end
            MTHI: exp_hi = a;
            MTLO: exp_lo = a;
            default: ;
        endcase
    endtask

    task automatic check_hilo(input string tag);
        HiLoSel = 1'b0; #1;
        check({tag, "_lo"}, HiLoOut, exp_lo);
        HiLoSel = 1'b1; #1;
        check({tag, "_hi"}, HiLoOut, exp_hi);
    endtask

    // Issue one op; inject > 0 raises a MULT Start at edge E<inject> while busy.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int inject);
        bit is_long, dz, seen, busy_ok;
        int cyc;
        @(negedge CLK);
        Start = 1'b1; Op = op; SrcA = a; SrcB = b;
        @(posedge CLK); #1;
        Start = 1'b0; Op = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
        model_op(op, a, b, is_long, dz);
        if (is_long) begin
            seen = 1'b0; busy_ok = 1'b1; cyc = 0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge CLK);
                Start = 1'b0;
                if (Done) begin
                    seen = 1'b1; cyc = i;
                    break;
                end
                if (!Busy) busy_ok = 1'b0;
                if (i == inject) begin
                    Start = 1'b1; Op = MULT; SrcA = $urandom; SrcB = $urandom;
                end
            end
            check("done_seen", 32'(seen), 32'd1);
            check("latency", 32'(cyc), 32'd33);
            check("busy_during", 32'(busy_ok), 32'd1);
            check("busy_at_done", 32'(Busy), 32'd0);
            check("divzero", 32'(DivZero), 32'(dz));
            @(negedge CLK);
            check("done_pulse", 32'(Done), 32'd0);
            check("divzero_pulse", 32'(DivZero), 32'd0);
        end else begin
            @(negedge CLK);
            check("busy_idle", 32'(Busy), 32'd0);
            check("done_idle", 32'(Done), 32'd0);
        end
        check_hilo("result");
        $display("op=%0d a=%08h b=%08h hi=%08h lo=%08h", op, a, b, exp_hi, exp_lo);
    endtask

    initial begin
        bit late_done;
        prim = DIV_EN ? DIV : MULT;
        rst = 1'b0; Start = 1'b0; Op = NOP; SrcA = '0; SrcB = '0; HiLoSel = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_divzero", 32'(DivZero), 32'd0);
        exp_hi = '0; exp_lo = '0;
        check_hilo("rst");
        rst = 1'b1;

        do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(MULT,  32'hFFFF_FFFD, 32'd7, 0);
        do_op(DIV,   32'hFFFF_FFF9, 32'd2, 0);
        do_op(DIVU,  32'd100, 32'd7, 0);
        do_op(DIVU,  32'd5, 32'd0, 0);
        do_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(MTHI,  32'h0000_1234, 32'd0, 0);
        do_op(MTLO,  32'hCAFE_F00D, 32'd0, 0);
        do_op(NOP,   32'h1111_1111, 32'h2222_2222, 0);
        do_op(prim,  32'h1234_5678, 32'h0000_9ABC, 5);

        // Reset at E10 of a running op abandons it without touching HI/LO afterwards.
        @(negedge CLK);
        Start = 1'b1; Op = prim; SrcA = 32'h7654_3210; SrcB = 32'd13;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (10) @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
        rst = 1'b1;
        exp_hi = '0; exp_lo = '0;
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_done", 32'(Done), 32'd0);
        check_hilo("midrst");
        late_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Done) late_done = 1'b1;
        end
        check("midrst_no_done", 32'(late_done), 32'd0);
        do_op(MULTU, 32'd3, 32'd4, 0);

        for (int n = 0; n < 40; n++) begin
            do_op(3'($urandom_range(0, 7)), rand_val(), rand_val(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
